// File: rtl/bit_destuffer.sv
// CAN bit destuffer: flags dynamic stuff bits and stuff errors in the sampled bit
// stream, and keeps a Gray-coded, parity-protected mod-8 count of stuff bits for CAN FD.
module bit_destuffer #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned RUN_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             samplePoint,
  input  logic             canRX,
  input  logic             BS_onoff,
  input  logic             clrCount,
  output logic             isStuff,
  output logic             stuffError,
  output logic             lastBit,
  output logic [RUN_W-1:0] runLen,
  output logic [2:0]       stuffCount,
  output logic [2:0]       stuffGray,
  output logic             stuffParity
);

  localparam logic [RUN_W-1:0] RUN_ZERO  = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_STUFF = RUN_W'(STUFF_LEN);

  function automatic logic [2:0] gray3(input logic [2:0] c);
    gray3 = c ^ (c >> 1);
  endfunction

  function automatic logic even_parity3(input logic [2:0] v);
    even_parity3 = ^v;
  endfunction

  logic             is_stuff_q,  is_stuff_d;
  logic             stuff_err_q, stuff_err_d;
  logic             last_bit_q,  last_bit_d;
  logic [RUN_W-1:0] run_len_q,   run_len_d;
  logic [2:0]       count_q,     count_d;
  logic [2:0]       gray_q,      gray_d;
  logic             parity_q,    parity_d;

  // Per-bit destuffing decision; everything holds between sample points.
  always_comb begin
    is_stuff_d  = is_stuff_q;
    stuff_err_d = stuff_err_q;
    last_bit_d  = last_bit_q;
    run_len_d   = run_len_q;
    count_d     = count_q;
    if (samplePoint) begin
      if (!BS_onoff) begin
        run_len_d   = RUN_ZERO;
        is_stuff_d  = 1'b0;
        stuff_err_d = 1'b0;
        last_bit_d  = canRX;
      end else if (run_len_q == RUN_STUFF) begin
        if (canRX != last_bit_q) begin
          // The stuff bit opens the next run, so the run restarts at one.
          is_stuff_d  = 1'b1;
          stuff_err_d = 1'b0;
          run_len_d   = RUN_ONE;
          last_bit_d  = canRX;
          count_d     = count_q + 3'd1;
        end else begin
          is_stuff_d  = 1'b0;
          stuff_err_d = 1'b1;
          run_len_d   = RUN_ZERO;
          last_bit_d  = canRX;
        end
      end else begin
        is_stuff_d  = 1'b0;
        stuff_err_d = 1'b0;
        last_bit_d  = canRX;
        if (run_len_q == RUN_ZERO) begin
          run_len_d = RUN_ONE;
        end else if (canRX == last_bit_q) begin
          run_len_d = run_len_q + RUN_ONE;
        end else begin
          run_len_d = RUN_ONE;
        end
      end
    end else begin
      is_stuff_d = is_stuff_q;
    end
    if (clrCount) begin
      count_d = 3'd0;
    end else begin
      count_d = count_d;
    end
    gray_d   = gray3(count_d);
    parity_d = even_parity3(gray_d);
  end

  // State registers; reset leaves the bus recessive with no run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_stuff_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      last_bit_q  <= 1'b1;
      run_len_q   <= RUN_ZERO;
      count_q     <= 3'd0;
      gray_q      <= 3'd0;
      parity_q    <= 1'b0;
    end else begin
      is_stuff_q  <= is_stuff_d;
      stuff_err_q <= stuff_err_d;
      last_bit_q  <= last_bit_d;
      run_len_q   <= run_len_d;
      count_q     <= count_d;
      gray_q      <= gray_d;
      parity_q    <= parity_d;
    end
  end

  assign isStuff     = is_stuff_q;
  assign stuffError  = stuff_err_q;
  assign lastBit     = last_bit_q;
  assign runLen      = run_len_q;
  assign stuffCount  = count_q;
  assign stuffGray   = gray_q;
  assign stuffParity = parity_q;

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer: hand-computed expectations checked with
// immediate assertions after each processed bit.
module tb_bit_destuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       samplePoint;
  logic       canRX;
  logic       BS_onoff;
  logic       clrCount;
  logic       isStuff;
  logic       stuffError;
  logic       lastBit;
  logic [2:0] runLen;
  logic [2:0] stuffCount;
  logic [2:0] stuffGray;
  logic       stuffParity;

  int n_checks = 0;
  int n_fail   = 0;
  logic lvl;

  bit_destuffer #(.STUFF_LEN(5), .RUN_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .samplePoint(samplePoint), .canRX(canRX),
    .BS_onoff(BS_onoff), .clrCount(clrCount), .isStuff(isStuff),
    .stuffError(stuffError), .lastBit(lastBit), .runLen(runLen),
    .stuffCount(stuffCount), .stuffGray(stuffGray), .stuffParity(stuffParity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic st, input logic er, input logic lb,
                         input logic [2:0] rl, input logic [2:0] cnt,
                         input logic [2:0] gr, input logic par);
    chk({tag, ".isStuff"},     {7'd0, isStuff},     {7'd0, st});
    chk({tag, ".stuffError"},  {7'd0, stuffError},  {7'd0, er});
    chk({tag, ".lastBit"},     {7'd0, lastBit},     {7'd0, lb});
    chk({tag, ".runLen"},      {5'd0, runLen},      {5'd0, rl});
    chk({tag, ".stuffCount"},  {5'd0, stuffCount},  {5'd0, cnt});
    chk({tag, ".stuffGray"},   {5'd0, stuffGray},   {5'd0, gr});
    chk({tag, ".stuffParity"}, {7'd0, stuffParity}, {7'd0, par});
  endtask

  // One samplePoint pulse; outputs are valid at the following negedge.
  task automatic send(input logic b, input logic clr);
    @(negedge clk);
    canRX       = b;
    clrCount    = clr;
    samplePoint = 1'b1;
    @(negedge clk);
    samplePoint = 1'b0;
    clrCount    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; samplePoint = 1'b0; canRX = 1'b1; BS_onoff = 1'b1; clrCount = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'b000, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Five dominant bits then a recessive stuff bit.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    chk_all("run5", 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 3'b000, 1'b0);
    send(1'b1, 1'b0);
    chk_all("stuff1", 1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 3'b001, 1'b1);

    // Bus activity without samplePoint must not disturb the held outputs.
    @(negedge clk); canRX = 1'b0; BS_onoff = 1'b0;
    repeat (3) @(negedge clk);
    BS_onoff = 1'b1;
    chk_all("hold", 1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 3'b001, 1'b1);

    // Stuff bit counts toward the run: four more ones reach five.
    send(1'b1, 1'b0);
    chk_all("after_stuff", 1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 3'b001, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    chk("run5b.runLen", {5'd0, runLen}, 8'd5);
    send(1'b0, 1'b0);
    chk_all("stuff2", 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'b011, 1'b0);

    // Six equal recessive bits: stuff error on the sixth.
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    chk_all("pre_err", 1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 3'b011, 1'b0);
    send(1'b1, 1'b0);
    chk_all("stuff_err", 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 3'b011, 1'b0);
    send(1'b1, 1'b0);
    chk_all("post_err", 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'b011, 1'b0);

    // clrCount alone, without a samplePoint.
    @(negedge clk); clrCount = 1'b1;
    @(negedge clk); clrCount = 1'b0;
    chk_all("clr", 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'b000, 1'b0);

    // Nine stuff events from a cleared count, checking 3, wrap at 8, and 9.
    lvl = 1'b1;
    for (int ev = 1; ev <= 9; ev++) begin
      for (int i = 0; i < 4; i++) send(lvl, 1'b0);
      lvl = ~lvl;
      send(lvl, 1'b0);
      if (ev == 3) chk_all("cnt3", 1'b1, 1'b0, lvl, 3'd1, 3'd3, 3'b010, 1'b1);
      if (ev == 8) chk_all("cnt8", 1'b1, 1'b0, lvl, 3'd1, 3'd0, 3'b000, 1'b0);
      if (ev == 9) chk_all("cnt9", 1'b1, 1'b0, lvl, 3'd1, 3'd1, 3'b001, 1'b1);
    end

    // clrCount on the same bit as a stuff bit: clear wins.
    for (int i = 0; i < 4; i++) send(lvl, 1'b0);
    lvl = ~lvl;
    send(lvl, 1'b1);
    chk_all("clr_vs_stuff", 1'b1, 1'b0, lvl, 3'd1, 3'd0, 3'b000, 1'b0);

    // Destuffing off: ten dominant bits never stuff or error.
    BS_onoff = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'b0);
      chk("off.isStuff", {7'd0, isStuff}, 8'd0);
      chk("off.stuffError", {7'd0, stuffError}, 8'd0);
      chk("off.runLen", {5'd0, runLen}, 8'd0);
    end
    chk_all("off_end", 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'b000, 1'b0);

    // Enable between samplePoints; first bit starts a run of one.
    BS_onoff = 1'b1;
    send(1'b0, 1'b0);
    chk_all("enable", 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    chk("pre_rst.runLen", {5'd0, runLen}, 8'd4);

    // Asynchronous reset mid-cycle acts immediately.
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'b000, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    send(1'b0, 1'b0);
    chk_all("after_rst", 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'b000, 1'b0);

    // samplePoint held on two consecutive clocks is two bits.
    @(negedge clk); canRX = 1'b0; samplePoint = 1'b1;
    @(negedge clk);
    @(negedge clk); samplePoint = 1'b0;
    chk("consec.runLen", {5'd0, runLen}, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
